// File: rtl/priority_encoder_8_3_pkg.sv
// Shared constants, the 3-to-8 onehot helper and the control state type
// for the registered 8-to-3 priority encoder.
package enc_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot = N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/priority_encoder_8_3_if.sv
// Request/handshake bundle between request sources, the encoder and its consumer.
// Handshake: y is offered while valid=1 and must stay stable until ack=1 is seen
// on a rising edge; ack while valid=0 has no effect.
interface priority_encoder_8_3_if;
   import enc_pkg::*;

   logic             en;
   logic [N_REQ-1:0] req;
   logic             ack;
   logic [IDX_W-1:0] y;
   logic             valid;
   logic [N_REQ-1:0] pending;

   modport master (
      output en, req, ack,
      input  y, valid, pending
   );

   modport slave (
      input  en, req, ack,
      output y, valid, pending
   );
endinterface

// File: rtl/priority_encoder_8_3_penc4.sv
// Combinational 4-to-2 priority encoder; bit 3 has the highest priority.
module priority_encoder_4_2 (
   input  logic [3:0] a,
   output logic [1:0] y,
   output logic       v
);

   always_comb begin
      y = 2'd0;
      v = 1'b1;
      casez (a)
         4'b1???: y = 2'd3;
         4'b01??: y = 2'd2;
         4'b001?: y = 2'd1;
         4'b0001: y = 2'd0;
         default: v = 1'b0;
      endcase
   end

endmodule

// File: rtl/priority_encoder_8_3.sv
// Registered 8-to-3 priority encoder: latches requests into a pending vector and
// presents the highest pending index with a valid/ack handshake.
module priority_encoder_8_3
   import enc_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   priority_encoder_8_3_if.slave     bus,
   output state_e                    state_o
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] y_q, y_d;
   logic             valid_q, valid_d;
   logic [N_REQ-1:0] pending_q, pending_d;

   logic [N_REQ-1:0] req_m;
   logic [N_REQ-1:0] clr;
   logic [1:0]       y_hi, y_lo;
   logic             v_hi, v_lo;
   logic [IDX_W-1:0] sel_y;
   logic             sel_any;

   // A request on the index being retired re-arms it: set wins over clear.
   always_comb begin
      req_m     = bus.en ? bus.req : '0;
      clr       = (valid_q && bus.ack) ? onehot(y_q) : '0;
      pending_d = (pending_q & ~clr) | req_m;
   end

   priority_encoder_4_2 u_penc_hi (
      .a (pending_d[7:4]),
      .y (y_hi),
      .v (v_hi)
   );

   priority_encoder_4_2 u_penc_lo (
      .a (pending_d[3:0]),
      .y (y_lo),
      .v (v_lo)
   );

   always_comb begin
      sel_y   = v_hi ? {1'b1, y_hi} : {1'b0, y_lo};
      sel_any = v_hi | v_lo;
   end

   // While presenting without ack, y and valid are frozen (no preemption).
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (sel_any) begin
               state_d = PRESENT;
               valid_d = 1'b1;
               y_d     = sel_y;
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               if (sel_any) begin
                  y_d = sel_y;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         y_q       <= '0;
         valid_q   <= 1'b0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
      end
   end

   assign bus.y       = y_q;
   assign bus.valid   = valid_q;
   assign bus.pending = pending_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_priority_encoder_8_3.sv
// Self-checking bench for priority_encoder_8_3: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the encoder.
module tb_priority_encoder_8_3;
   import enc_pkg::*;

   logic   clk;
   logic   rst_n;
   state_e state_dbg;

   priority_encoder_8_3_if bus ();

   priority_encoder_8_3 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   // Behavioural model state: what the outputs must be after the next edge.
   logic [7:0] m_pending;
   logic [2:0] m_y;
   logic       m_valid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int highest_bit(input logic [7:0] v);
      highest_bit = -1;
      for (int i = 0; i < 8; i++)
         if (v[i]) highest_bit = i;
   endfunction

   task automatic model_reset();
      m_pending = 8'h00;
      m_y       = 3'd0;
      m_valid   = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic [7:0] req, input logic ack);
      logic [7:0] nxt;
      int         hb;
      nxt = m_pending;
      if (m_valid && ack) nxt[m_y] = 1'b0;
      if (en) nxt = nxt | req;
      m_pending = nxt;
      if (!m_valid || ack) begin
         hb = highest_bit(nxt);
         if (hb >= 0) begin
            m_y     = 3'(hb);
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs between edges; optionally release reset in the same half-cycle.
   task automatic cycle(input logic en, input logic [7:0] req, input logic ack,
                        input bit release_rst = 1'b0);
      @(negedge clk);
      if (release_rst) rst_n = 1'b1;
      bus.en  = en;
      bus.req = req;
      bus.ack = ack;
      if (rst_n) model_step(en, req, ack);
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (cmp_on) begin
         n_checks++;
         if (bus.valid !== m_valid || bus.pending !== m_pending || bus.y !== m_y) begin
            n_fail++;
            $display("FAIL model: got valid=%0b y=%0d pending=0x%02h, expected valid=%0b y=%0d pending=0x%02h at %0t",
                     bus.valid, bus.y, bus.pending, m_valid, m_y, m_pending, $time);
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      bus.en  = 1'b1;
      bus.req = 8'hFF;
      bus.ack = 1'b0;
      model_reset();
      cmp_on = 1'b1;

      // Requests during reset are lost.
      cycle(1'b1, 8'hFF, 1'b0);
      cycle(1'b1, 8'hFF, 1'b1);
      chk("reset_valid", 8'(bus.valid), 8'h00);
      chk("reset_y", 8'(bus.y), 8'h00);
      chk("reset_pending", bus.pending, 8'h00);

      cycle(1'b1, 8'h01, 1'b0, 1'b1);
      chk("first_capture_valid", 8'(bus.valid), 8'h01);
      chk("first_capture_pending", bus.pending, 8'h01);
      cycle(1'b1, 8'h00, 1'b1);
      chk("first_drain_valid", 8'(bus.valid), 8'h00);

      // Basic handshake.
      cycle(1'b1, 8'h24, 1'b0);
      chk("basic_y5", 8'(bus.y), 8'd5);
      chk("basic_pending", bus.pending, 8'h24);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
      chk("hold_y5", 8'(bus.y), 8'd5);
      cycle(1'b1, 8'h00, 1'b1);
      chk("ack_y2", 8'(bus.y), 8'd2);
      chk("ack_pending", bus.pending, 8'h04);

      // No preemption by a later higher-priority request.
      cycle(1'b1, 8'h80, 1'b0);
      chk("nopreempt_y2", 8'(bus.y), 8'd2);
      cycle(1'b1, 8'h00, 1'b1);
      chk("after_ack_y7", 8'(bus.y), 8'd7);
      cycle(1'b1, 8'h00, 1'b1);
      chk("empty_valid", 8'(bus.valid), 8'h00);
      chk("empty_y_kept", 8'(bus.y), 8'd7);
      chk("empty_pending", bus.pending, 8'h00);

      // Set wins over clear.
      cycle(1'b1, 8'h08, 1'b0);
      cycle(1'b1, 8'h08, 1'b1);
      chk("setclr_valid", 8'(bus.valid), 8'h01);
      chk("setclr_y3", 8'(bus.y), 8'd3);
      chk("setclr_pending", bus.pending, 8'h08);
      cycle(1'b1, 8'h00, 1'b1);

      // Enable gating.
      cycle(1'b0, 8'hFF, 1'b0);
      cycle(1'b0, 8'hFF, 1'b1);
      chk("en_gate_pending", bus.pending, 8'h00);
      chk("en_gate_valid", 8'(bus.valid), 8'h00);

      // Full drain 7..0 under continuous ack.
      cycle(1'b1, 8'hFF, 1'b0);
      chk("full_y7", 8'(bus.y), 8'd7);
      for (int i = 6; i >= 0; i--) begin
         cycle(1'b1, 8'h00, 1'b1);
         chk("drain_y", 8'(bus.y), 8'(i));
      end
      cycle(1'b1, 8'h00, 1'b1);
      chk("drain_valid", 8'(bus.valid), 8'h00);
      chk("drain_pending", bus.pending, 8'h00);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [7:0] r;
         r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
         cycle(1'($urandom_range(0, 7) != 0), r, 1'($urandom_range(0, 1)));
      end
      for (int n = 0; n < 10; n++) cycle(1'b1, 8'h00, 1'b1);

      // Asynchronous reset between edges.
      cycle(1'b1, 8'hF0, 1'b0);
      chk("pre_rst_pending", bus.pending, 8'hF0);
      chk("pre_rst_y", 8'(bus.y), 8'd7);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_valid", 8'(bus.valid), 8'h00);
      chk("async_y", 8'(bus.y), 8'h00);
      chk("async_pending", bus.pending, 8'h00);
      cycle(1'b1, 8'h00, 1'b0);
      cycle(1'b1, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h00, 1'b0);
      chk("post_rst_valid", 8'(bus.valid), 8'h00);

      cmp_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/priority_encoder_8_3.md
# priority_encoder_8_3

Registered 8-to-3 priority encoder with request latching and a valid/ack handshake. It is the encoding counterpart of the 3-to-8 decoder. Up to eight request lines are captured into a pending register, and the index of the highest-priority pending request is presented on `y` with `valid`. The consumer acknowledges each index, which retires that request. It sits between request sources (interrupt-style lines) and a consumer that selects targets by index through the decoder.

## Interface
- No parameters. Width is fixed at 8 requests and a 3-bit index; constants come from the shared package.

Ports (clock and reset are `clk` and `rst_n`):
- `clk`  in  1  Single clock; all state updates on rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `en`  in  1  Request capture enable; when 0, `req` is ignored.
- `req`  in  8  Request lines, sampled every cycle; bit 7 is highest priority.
- `ack`  in  1  Consumer accepts current `y`; meaningful only while `valid`=1.
- `y`  out  3  Index of the presented request.
- `valid`  out  1  `y` holds a pending request.
- `pending`  out  8  Registered pending-request vector.

## Operation
- Internal signals:
  - `req_m = en ? req : 0`.
  - `clr = (valid & ack) ? onehot(y) : 0`.
  - `pending_next = (pending & ~clr) | req_m`. Set wins over clear: a request on the acked index in the same cycle re-arms that bit.
- Two-state control (IDLE: `valid`=0; PRESENT: `valid`=1):
  - IDLE: each cycle, `valid_next = |pending_next` and `y_next = penc(pending_next)`.
  - PRESENT with `ack`=0: `y` and `valid` are held. No preemption; a newly arrived higher-priority request waits.
  - PRESENT with `ack`=1: reselect from `pending_next`. If it is non-zero, stay in PRESENT with the new `y`. Otherwise go to IDLE.
- `penc`: highest set bit wins. The result is don't-care when the input is 0; `y` is then held at its old value.
- `ack` while `valid`=0 is ignored.
- `en`=0 blocks capture only. Handshake and retirement continue normally.
- Repeated requests on an already-pending bit merge. There is no counting.

## Timing
- Reset values: `y`=0, `valid`=0, `pending`=0. All state clears immediately on `rst_n` falling, independent of `clk`.
- Requests asserted while `rst_n`=0 are lost. The first capture happens on the first rising edge after release.
- Latency: `req` high before edge k, with the block in IDLE, gives `valid`=1 and the correct `y` after edge k (1 cycle).
- Throughput: back-to-back. With `ack` held high, one index is retired per cycle.
- `y` must not change while `valid`=1 and `ack`=0.
- `pending` reflects `pending_next` after each edge. An acked bit is cleared in the same edge that presents the next index.
- Empty case: after the last ack, `valid` drops at that edge and `y` keeps the last index.
- Full case (`pending`=0xFF): indices are presented 7, 6, … 0 under continuous ack, absent new requests.

## Structure
- Shared package `enc_pkg`:
  - `N_REQ`=8, `IDX_W`=3.
  - `onehot(idx)` function (3→8).
  - State enum {IDLE, PRESENT}.
- Sub-module `priority_encoder_4_2` (combinational: `a[3:0]` → `y[1:0]`, `v`).
  - Two instances cover `pending_next[7:4]` and `pending_next[3:0]`.
  - The upper instance wins: `y = v_hi ? {1'b1, y_hi} : {1'b0, y_lo}`, and `any = v_hi | v_lo`. This mirrors the decoder's split on the MSB.
- The top level holds the pending register, the FSM and the output registers.

## Test plan
- Reset: drive `rst_n`=0 with `req`=0xFF and `en`=1 → `valid`=0, `y`=0, `pending`=0 throughout. After release, the first capture occurs on the next edge.
- Basic handshake:
  - Drive one-cycle `req`=0x24 with `en`=1 → `valid`=1, `y`=5, `pending`=0x24.
  - Hold `ack`=0 for 3 cycles → `y` stays 5.
  - Pulse `ack` → `y`=2, `pending`=0x04.
  - Pulse `ack` → `valid`=0, `pending`=0.
- No preemption: with `y`=2 presented, drive `req`=0x80 → `y` stays 2 until `ack`, then `y`=7.
- Set-over-clear: with `y`=3 presented, drive `ack`=1 and `req`=0x08 together → `valid`=1, `y`=3, `pending`=0x08.
- Enable gating and full drain:
  - `en`=0 with `req`=0xFF → `pending` unchanged at 0.
  - Load 0xFF with `en`=1, then hold `ack`=1 → `y` runs 7…0 on consecutive cycles, then `valid`=0.
- Async reset mid-operation: with `pending`=0xF0 and `valid`=1, assert `rst_n`=0 between edges → outputs clear immediately. After release, with `req`=0, `valid` stays 0.
